id_ex_stage: RTL and testbench

//  ID/EX pipeline stage: registers decoded control (ALUop, ALUsrc, MtoR, regwrite, memread,

---
 rtl/id_ex_stage.sv | 185 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch-flush squash
// and a saturating bubble counter.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [6:0]       id_op,
  input  logic [1:0]       id_aluop,
  input  logic             id_alusrc,
  input  logic             id_mtor,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_branch,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7b5,
  input  logic             flush,
  output logic             stall,
  output logic             ex_valid,
  output logic [1:0]       ex_aluop,
  output logic             ex_alusrc,
  output logic             ex_mtor,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_branch,
  output logic [RA_W-1:0]  ex_rs1,
  output logic [RA_W-1:0]  ex_rs2,
  output logic [RA_W-1:0]  ex_rd,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_pc,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             valid_q, valid_d;
  logic [1:0]       aluop_q, aluop_d;
  logic             alusrc_q, alusrc_d, mtor_q, mtor_d, regwrite_q, regwrite_d;
  logic             memread_q, memread_d, memwrite_q, memwrite_d, branch_q, branch_d;
  logic [RA_W-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0]  rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]  imm_q, imm_d, pc_q, pc_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             funct7b5_q, funct7b5_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             use_rs1, use_rs2, hazard;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (id_op)
      7'b0110011, 7'b1100011, 7'b0100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0000011, 7'b0010011: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  // x0 is hard-wired, so a load targeting it never creates a dependency
  assign hazard = id_valid & valid_q & memread_q & (rd_q != '0) &
                  ((use_rs1 & (id_rs1 == rd_q)) | (use_rs2 & (id_rs2 == rd_q)));
  assign stall  = hazard & ~flush;

  always_comb begin
    valid_d    = 1'b0;
    aluop_d    = '0;
    alusrc_d   = 1'b0;
    mtor_d     = 1'b0;
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    branch_d   = 1'b0;
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    rs1_data_d = '0;
    rs2_data_d = '0;
    imm_d      = '0;
    pc_d       = '0;
    funct3_d   = '0;
    funct7b5_d = 1'b0;
    if (!flush && !hazard) begin
      valid_d = id_valid;
      if (id_valid) begin
        aluop_d    = id_aluop;
        alusrc_d   = id_alusrc;
        mtor_d     = id_mtor;
        regwrite_d = id_regwrite;
        memread_d  = id_memread;
        memwrite_d = id_memwrite;
        branch_d   = id_branch;
      end
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      pc_d       = id_pc;
      funct3_d   = id_funct3;
      funct7b5_d = id_funct7b5;
    end
    cnt_d = cnt_q;
    if ((flush || hazard) && id_valid && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      aluop_q    <= '0;
      alusrc_q   <= 1'b0;
      mtor_q     <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      branch_q   <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      aluop_q    <= aluop_d;
      alusrc_q   <= alusrc_d;
      mtor_q     <= mtor_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      branch_q   <= branch_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      funct3_q   <= funct3_d;
      funct7b5_q <= funct7b5_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_aluop    = aluop_q;
  assign ex_alusrc   = alusrc_q;
  assign ex_mtor     = mtor_q;
  assign ex_regwrite = regwrite_q;
  assign ex_memread  = memread_q;
  assign ex_memwrite = memwrite_q;
  assign ex_branch   = branch_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_imm      = imm_q;
  assign ex_pc       = pc_q;
  assign ex_funct3   = funct3_q;
  assign ex_funct7b5 = funct7b5_q;
  assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes expected stall / EX contents,
// a negedge monitor pops and compares. A CNT_W=2 copy checks counter saturation.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [6:0]  op;
    logic [1:0]  aluop;
    logic        alusrc, mtor, regwrite, memread, memwrite, branch;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1d, rs2d, imm, pc;
    logic [2:0]  f3;
    logic        f7;
  } id_t;

  typedef struct packed {
    logic        valid;
    logic [1:0]  aluop;
    logic        alusrc, mtor, regwrite, memread, memwrite, branch;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1d, rs2d, imm, pc;
    logic [2:0]  f3;
    logic        f7;
  } ex_t;

  typedef struct {
    int          cyc;
    bit          is_ex;
    bit          stall;
    ex_t         ex;
    logic [15:0] cnt;
    logic [1:0]  sat;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_alusrc, id_mtor, id_regwrite, id_memread, id_memwrite, id_branch;
  logic [6:0] id_op;
  logic [1:0] id_aluop;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [2:0] id_funct3;
  logic id_funct7b5, flush;

  logic stall, ex_valid, ex_alusrc, ex_mtor, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
  logic [1:0] ex_aluop;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic [2:0] ex_funct3;
  logic ex_funct7b5;
  logic [15:0] bubble_cnt;

  logic s_stall, s_valid, s_alusrc, s_mtor, s_regwrite, s_memread, s_memwrite, s_branch;
  logic [1:0] s_aluop;
  logic [4:0] s_rs1, s_rs2, s_rd;
  logic [31:0] s_rs1_data, s_rs2_data, s_imm, s_pc;
  logic [2:0] s_funct3;
  logic s_funct7b5;
  logic [1:0] s_cnt;

  always #5 clk = ~clk;

  id_ex_stage u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_aluop(id_aluop),
    .id_alusrc(id_alusrc), .id_mtor(id_mtor), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .flush(flush), .stall(stall), .ex_valid(ex_valid),
    .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc), .ex_mtor(ex_mtor),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_branch(ex_branch), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_aluop(id_aluop),
    .id_alusrc(id_alusrc), .id_mtor(id_mtor), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .flush(flush), .stall(s_stall), .ex_valid(s_valid),
    .ex_aluop(s_aluop), .ex_alusrc(s_alusrc), .ex_mtor(s_mtor),
    .ex_regwrite(s_regwrite), .ex_memread(s_memread), .ex_memwrite(s_memwrite),
    .ex_branch(s_branch), .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd),
    .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data), .ex_imm(s_imm), .ex_pc(s_pc),
    .ex_funct3(s_funct3), .ex_funct7b5(s_funct7b5), .bubble_cnt(s_cnt)
  );

  item_t sb[$];
  int cyc_n = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_cnt = '0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic ex_t act_ex();
    ex_t a;
    a.valid = ex_valid; a.aluop = ex_aluop; a.alusrc = ex_alusrc; a.mtor = ex_mtor;
    a.regwrite = ex_regwrite; a.memread = ex_memread; a.memwrite = ex_memwrite;
    a.branch = ex_branch; a.rs1 = ex_rs1; a.rs2 = ex_rs2; a.rd = ex_rd;
    a.rs1d = ex_rs1_data; a.rs2d = ex_rs2_data; a.imm = ex_imm; a.pc = ex_pc;
    a.f3 = ex_funct3; a.f7 = ex_funct7b5;
    return a;
  endfunction

  always @(negedge clk) begin
    item_t it;
    ex_t a;
    while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
      it = sb.pop_front();
      n_cmp++;
      if (it.cyc != cyc_n) begin
        n_bad++;
        $display("FAIL sb_stale cyc=%0d item_cyc=%0d required=%0d", cyc_n, it.cyc, cyc_n);
      end else if (!it.is_ex) begin
        if (stall !== it.stall) begin
          n_bad++;
          $display("FAIL stall cyc=%0d got=%b required=%b", cyc_n, stall, it.stall);
        end
      end else begin
        a = act_ex();
        if (a !== it.ex) begin
          n_bad++;
          $display("FAIL ex_bundle cyc=%0d got=%h required=%h", cyc_n, a, it.ex);
        end
        n_cmp++;
        if (bubble_cnt !== it.cnt) begin
          n_bad++;
          $display("FAIL bubble_cnt cyc=%0d got=%0d required=%0d", cyc_n, bubble_cnt, it.cnt);
        end
        n_cmp++;
        if (s_cnt !== it.sat) begin
          n_bad++;
          $display("FAIL sat_cnt cyc=%0d got=%0d required=%0d", cyc_n, s_cnt, it.sat);
        end
      end
    end
  end

  function automatic id_t mk(bit v, logic [6:0] op, logic [1:0] aluop, bit src, bit mtor,
                             bit rw, bit mr, bit mw, bit br,
                             logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    id_t i;
    i.valid = v; i.op = op; i.aluop = aluop; i.alusrc = src; i.mtor = mtor;
    i.regwrite = rw; i.memread = mr; i.memwrite = mw; i.branch = br;
    i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    i.rs1d = $urandom; i.rs2d = $urandom; i.imm = $urandom; i.pc = $urandom;
    i.f3 = 3'($urandom_range(7)); i.f7 = 1'($urandom_range(1));
    return i;
  endfunction

  function automatic id_t rtype(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return mk(1, 7'b0110011, 2'b10, 0, 0, 1, 0, 0, 0, rd, rs1, rs2);
  endfunction
  function automatic id_t load(logic [4:0] rd, logic [4:0] rs1);
    return mk(1, 7'b0000011, 2'b00, 1, 1, 1, 1, 0, 0, rd, rs1, 5'd0);
  endfunction

  // Expected EX image of an ID instruction that passes (or a bubble).
  function automatic ex_t exp_of(id_t i, bit bub);
    ex_t e;
    e = '0;
    if (!bub) begin
      e.valid = i.valid;
      if (i.valid) begin
        e.aluop = i.aluop; e.alusrc = i.alusrc; e.mtor = i.mtor; e.regwrite = i.regwrite;
        e.memread = i.memread; e.memwrite = i.memwrite; e.branch = i.branch;
      end
      e.rs1 = i.rs1; e.rs2 = i.rs2; e.rd = i.rd; e.rs1d = i.rs1d; e.rs2d = i.rs2d;
      e.imm = i.imm; e.pc = i.pc; e.f3 = i.f3; e.f7 = i.f7;
    end
    return e;
  endfunction

  task automatic drive(id_t i, bit f);
    id_valid = i.valid; id_op = i.op; id_aluop = i.aluop; id_alusrc = i.alusrc;
    id_mtor = i.mtor; id_regwrite = i.regwrite; id_memread = i.memread;
    id_memwrite = i.memwrite; id_branch = i.branch; id_rs1 = i.rs1; id_rs2 = i.rs2;
    id_rd = i.rd; id_rs1_data = i.rs1d; id_rs2_data = i.rs2d; id_imm = i.imm;
    id_pc = i.pc; id_funct3 = i.f3; id_funct7b5 = i.f7; flush = f;
  endtask

  task automatic push(int c, bit is_ex, bit st, ex_t e);
    item_t it;
    it.cyc = c; it.is_ex = is_ex; it.stall = st; it.ex = e;
    it.cnt = exp_cnt; it.sat = (exp_cnt > 16'd3) ? 2'd3 : exp_cnt[1:0];
    sb.push_back(it);
  endtask

  task automatic step(id_t i, bit f, bit exp_stall, bit exp_bub);
    rst = 1'b0;
    drive(i, f);
    push(cyc_n, 1'b0, exp_stall, '0);
    if (exp_bub && i.valid) exp_cnt = exp_cnt + 16'd1;
    push(cyc_n + 1, 1'b1, 1'b0, exp_of(i, exp_bub));
    @(posedge clk); #1;
  endtask

  initial begin
    id_t inv, lui;
    rst = 1'b1;
    drive(mk(1'($urandom_range(1)), 7'($urandom), 2'($urandom), 1, 1, 1, 1, 1, 1,
             5'($urandom), 5'($urandom), 5'($urandom)), 1'($urandom_range(1)));
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      push(cyc_n, 1'b0, 1'b0, '0);
      push(cyc_n, 1'b1, 1'b0, '0);
      drive(mk(1, 7'b0000011, 2'($urandom), 1, 1, 1, 1, 1, 1,
               5'($urandom), 5'($urandom), 5'($urandom)), 1'($urandom_range(1)));
    end

    step(rtype(5'd5, 5'd1, 5'd2), 0, 0, 0);          // add x5 passes in one cycle
    step(load(5'd6, 5'd3), 0, 0, 0);
    step(rtype(5'd7, 5'd1, 5'd6), 0, 1, 1);          // load-use on rs2
    step(rtype(5'd7, 5'd1, 5'd6), 0, 0, 0);          // re-presented, stall cleared
    step(load(5'd6, 5'd3), 0, 0, 0);
    step(mk(1, 7'b0010011, 2'b10, 1, 0, 1, 0, 0, 0, 5'd8, 5'd7, 5'd6), 0, 0, 0);
    step(load(5'd9, 5'd2), 0, 0, 0);
    step(rtype(5'd10, 5'd9, 5'd1), 1, 0, 1);         // hazard + flush: flush wins
    step(load(5'd0, 5'd1), 0, 0, 0);
    step(mk(1, 7'b0100011, 2'b00, 1, 0, 0, 0, 1, 0, 5'd4, 5'd1, 5'd0), 0, 0, 0);
    step(load(5'd11, 5'd2), 0, 0, 0);
    inv = rtype(5'd3, 5'd11, 5'd11);
    inv.valid = 1'b0;
    step(inv, 0, 0, 0);                              // invalid ID: no stall, controls 0
    step(load(5'd12, 5'd2), 0, 0, 0);
    step(rtype(5'd14, 5'd12, 5'd3), 0, 1, 1);        // load-use on rs1
    step(rtype(5'd14, 5'd12, 5'd3), 0, 0, 0);
    step(load(5'd13, 5'd2), 0, 0, 0);
    lui = mk(1, 7'b0110111, 2'b00, 1, 0, 1, 0, 0, 0, 5'd15, 5'd13, 5'd13);
    step(lui, 0, 0, 0);                              // opcode reads no rs
    for (int k = 0; k < 5; k++)
      step(mk(1, 7'b1100011, 2'b01, 0, 0, 0, 0, 0, 1, 5'd0, 5'd1, 5'd2), 1, 0, 1);
    step(inv, 1, 0, 1);                              // flushed invalid slot: not counted
    step(rtype(5'd16, 5'd5, 5'd6), 0, 0, 0);
    step(inv, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain left=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
